// File: rtl/victim_way_sel.sv
// ---------------------------------------------------------------------------
// victim_way_sel
//
// Chooses the replacement way for a cache miss on the refill path. The first
// preference is the lowest-index way that is both invalid and unlocked. If no
// such way exists, the way index supplied by the upstream LFSR is used. If that
// way is locked, the search moves upward from it with wrap-around until it
// finds an unlocked way. When every way is locked, an error result is offered
// instead of a victim.
//
// The result is registered when the request is accepted. It is then offered to
// the refill controller over a valid/ready handshake. After the handshake the
// block stays busy until the refill completes. This block is the only driver
// of the LFSR's advance enable. It pulses that enable once, at the victim
// handshake, and only when the LFSR index influenced the choice.
//
// Ports
//   clk_i, rst_i          clock (rising edge) and synchronous active-high reset
//   req_valid_i/ready_o   miss request handshake (ready only while idle)
//   valid_ways_i          per-way line-valid mask, sampled at acceptance
//   lock_ways_i           per-way lock mask, sampled at acceptance
//   lfsr_way_bin_i        pseudo-random way index from the LFSR
//   lfsr_en_o             one-cycle advance pulse to the LFSR
//   victim_valid_o/ready_i victim result handshake
//   victim_way_oh_o       one-hot victim way
//   victim_way_bin_o      binary victim way
//   victim_evict_o        chosen way holds a valid line
//   victim_err_o          all ways locked, no victim
//   refill_done_i         refill completion pulse
//   busy_o                high whenever not idle
// ---------------------------------------------------------------------------
module victim_way_sel #(
    parameter int NR_WAYS  = 8,
    parameter int LOG_WAYS = $clog2(NR_WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [NR_WAYS-1:0]  valid_ways_i,
    input  logic [NR_WAYS-1:0]  lock_ways_i,
    input  logic [LOG_WAYS-1:0] lfsr_way_bin_i,
    output logic                lfsr_en_o,
    output logic                victim_valid_o,
    input  logic                victim_ready_i,
    output logic [NR_WAYS-1:0]  victim_way_oh_o,
    output logic [LOG_WAYS-1:0] victim_way_bin_o,
    output logic                victim_evict_o,
    output logic                victim_err_o,
    input  logic                refill_done_i,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    // Way count in index arithmetic width. One extra bit holds r + offset
    // before it is reduced back into range.
    localparam logic [LOG_WAYS:0] NR_WAYS_W = NR_WAYS[LOG_WAYS:0];

    // Maps an index in [0, 2*NR_WAYS) into [0, NR_WAYS) using one subtraction.
    function automatic logic [LOG_WAYS-1:0] wrap_idx(input logic [LOG_WAYS:0] idx);
        logic [LOG_WAYS:0] red;
        red = (idx >= NR_WAYS_W) ? (idx - NR_WAYS_W) : idx;
        return red[LOG_WAYS-1:0];
    endfunction

    // Converts a binary way index to its one-hot form.
    function automatic logic [NR_WAYS-1:0] bin2oh(input logic [LOG_WAYS-1:0] b);
        logic [NR_WAYS-1:0] one;
        one = {{(NR_WAYS-1){1'b0}}, 1'b1};
        return one << b;
    endfunction

    state_t                state_q, state_d;
    logic [LOG_WAYS-1:0]   way_bin_q, way_bin_d;
    logic [NR_WAYS-1:0]    way_oh_q, way_oh_d;
    logic                  evict_q, evict_d;
    logic                  err_q, err_d;
    logic                  used_lfsr_q, used_lfsr_d;

    logic                  free_found_s;
    logic [LOG_WAYS-1:0]   free_bin_s;
    logic                  lk_found_s;
    logic [LOG_WAYS-1:0]   lk_bin_s;
    logic [LOG_WAYS-1:0]   lfsr_r_s;
    logic [LOG_WAYS-1:0]   cand_s;
    logic                  hit_s;
    logic [LOG_WAYS-1:0]   sel_bin_s;
    logic [NR_WAYS-1:0]    sel_oh_s;
    logic                  sel_evict_s;
    logic                  sel_err_s;
    logic                  sel_used_s;

    // Victim selection from the current request inputs (used only at acceptance).
    always_comb begin
        free_found_s = 1'b0;
        free_bin_s   = {LOG_WAYS{1'b0}};
        lk_found_s   = 1'b0;
        lk_bin_s     = {LOG_WAYS{1'b0}};
        cand_s       = {LOG_WAYS{1'b0}};
        hit_s        = 1'b0;
        sel_bin_s    = {LOG_WAYS{1'b0}};
        sel_evict_s  = 1'b0;
        sel_err_s    = 1'b0;
        sel_used_s   = 1'b0;

        // Lowest-index invalid, unlocked way.
        for (int k = 0; k < NR_WAYS; k++) begin
            hit_s        = !free_found_s && !valid_ways_i[k] && !lock_ways_i[k];
            free_found_s = free_found_s | hit_s;
            free_bin_s   = hit_s ? k[LOG_WAYS-1:0] : free_bin_s;
        end

        // Upward search with wrap-around, starting at the reduced LFSR index.
        // Offset 0 is the LFSR way itself.
        lfsr_r_s = wrap_idx({1'b0, lfsr_way_bin_i});
        for (int k = 0; k < NR_WAYS; k++) begin
            cand_s     = wrap_idx({1'b0, lfsr_r_s} + k[LOG_WAYS:0]);
            hit_s      = !lk_found_s && !lock_ways_i[cand_s];
            lk_found_s = lk_found_s | hit_s;
            lk_bin_s   = hit_s ? cand_s : lk_bin_s;
        end

        if (free_found_s) begin
            sel_bin_s = free_bin_s;
        end else if (lk_found_s) begin
            sel_bin_s   = lk_bin_s;
            sel_evict_s = valid_ways_i[lk_bin_s];
            sel_used_s  = 1'b1;
        end else begin
            sel_err_s = 1'b1;
        end

        sel_oh_s = sel_err_s ? {NR_WAYS{1'b0}} : bin2oh(sel_bin_s);
    end

    // Next-state and result-register update logic.
    always_comb begin
        state_d     = state_q;
        way_bin_d   = way_bin_q;
        way_oh_d    = way_oh_q;
        evict_d     = evict_q;
        err_d       = err_q;
        used_lfsr_d = used_lfsr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    way_bin_d   = sel_bin_s;
                    way_oh_d    = sel_oh_s;
                    evict_d     = sel_evict_s;
                    err_d       = sel_err_s;
                    used_lfsr_d = sel_used_s;
                    state_d     = S_OFFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (victim_ready_i) begin
                    // An error result has no refill to wait for.
                    state_d = err_q ? S_IDLE : S_BUSY;
                end else begin
                    state_d = S_OFFER;
                end
            end
            S_BUSY: begin
                if (refill_done_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            way_bin_q   <= {LOG_WAYS{1'b0}};
            way_oh_q    <= {NR_WAYS{1'b0}};
            evict_q     <= 1'b0;
            err_q       <= 1'b0;
            used_lfsr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            way_bin_q   <= way_bin_d;
            way_oh_q    <= way_oh_d;
            evict_q     <= evict_d;
            err_q       <= err_d;
            used_lfsr_q <= used_lfsr_d;
        end
    end

    // Outputs decoded from the registered state. lfsr_en_o is combinational
    // with the handshake, so the LFSR advances exactly when the victim is taken.
    always_comb begin
        req_ready_o      = (state_q == S_IDLE);
        victim_valid_o   = (state_q == S_OFFER);
        busy_o           = (state_q != S_IDLE);
        lfsr_en_o        = (state_q == S_OFFER) && victim_ready_i && used_lfsr_q;
        victim_way_oh_o  = way_oh_q;
        victim_way_bin_o = way_bin_q;
        victim_evict_o   = evict_q;
        victim_err_o     = err_q;
    end

endmodule

// File: tb/tb_victim_way_sel.sv
module tb_victim_way_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulse4   = 0;
    int pulse3   = 0;

    // 4-way instance
    logic       rv4 = 1'b0, vr4 = 1'b0, done4 = 1'b0;
    logic [3:0] vw4 = 4'h0, lk4 = 4'h0;
    logic [1:0] lf4 = 2'd0;
    logic       rdy4, le4, vv4, ev4, er4, busy4;
    logic [3:0] oh4;
    logic [1:0] bin4;

    // 3-way instance (exercises LFSR index reduction)
    logic       rv3 = 1'b0, vr3 = 1'b0, done3 = 1'b0;
    logic [2:0] vw3 = 3'h0, lk3 = 3'h0;
    logic [1:0] lf3 = 2'd0;
    logic       rdy3, le3, vv3, ev3, er3, busy3;
    logic [2:0] oh3;
    logic [1:0] bin3;

    victim_way_sel #(.NR_WAYS(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv4), .req_ready_o(rdy4),
        .valid_ways_i(vw4), .lock_ways_i(lk4), .lfsr_way_bin_i(lf4),
        .lfsr_en_o(le4), .victim_valid_o(vv4), .victim_ready_i(vr4),
        .victim_way_oh_o(oh4), .victim_way_bin_o(bin4), .victim_evict_o(ev4),
        .victim_err_o(er4), .refill_done_i(done4), .busy_o(busy4)
    );

    victim_way_sel #(.NR_WAYS(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv3), .req_ready_o(rdy3),
        .valid_ways_i(vw3), .lock_ways_i(lk3), .lfsr_way_bin_i(lf3),
        .lfsr_en_o(le3), .victim_valid_o(vv3), .victim_ready_i(vr3),
        .victim_way_oh_o(oh3), .victim_way_bin_o(bin3), .victim_evict_o(ev3),
        .victim_err_o(er3), .refill_done_i(done3), .busy_o(busy3)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (le4 === 1'b1) pulse4 <= pulse4 + 1;
        if (le3 === 1'b1) pulse3 <= pulse3 + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: replacement choice stated directly from the selection rules.
    function automatic void model(input int n, input logic [15:0] v, input logic [15:0] l,
                                  input int r, output int bin, output bit err,
                                  output bit evict, output bit used);
        int rr;
        bin = 0; err = 1'b1; evict = 1'b0; used = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!v[i] && !l[i]) begin
                bin = i; err = 1'b0;
                return;
            end
        end
        rr = (r >= n) ? r - n : r;
        for (int k = 0; k < n; k++) begin
            int w;
            w = (rr + k) % n;
            if (!l[w]) begin
                bin = w; err = 1'b0; evict = v[w]; used = 1'b1;
                return;
            end
        end
    endfunction

    // Full request on the 4-way instance, with backpressure and refill delay.
    task automatic do_req4(input logic [3:0] v, input logic [3:0] l, input logic [1:0] r,
                           input int rdly, input int ddly);
        int eb; bit ee, eev, eu;
        logic [3:0] eoh;
        logic [10:0] exp_v, got_v;
        int p0;
        model(4, {12'h000, v}, {12'h000, l}, int'(r), eb, ee, eev, eu);
        eoh = ee ? 4'b0000 : 4'(1 << eb);
        n_checks++;
        if (rdy4 !== 1'b1) $display("FAIL idle_ready4 got=%b exp=1", rdy4); else n_pass++;
        vw4 = v; lk4 = l; lf4 = r; rv4 = 1'b1;
        p0 = pulse4;
        tick;
        rv4 = 1'b0; vw4 = 4'($urandom); lk4 = 4'($urandom);
        exp_v = {1'b1, 1'b0, 1'b1, eoh, 2'(eb), eev, ee};
        got_v = {vv4, rdy4, busy4, oh4, bin4, ev4, er4};
        n_checks++;
        if (got_v !== exp_v) $display("FAIL offer4 v=%b l=%b r=%0d got=%b exp=%b", v, l, r, got_v, exp_v);
        else n_pass++;
        for (int i = 0; i < rdly; i++) begin
            done4 = (i == 1);
            tick;
            done4 = 1'b0;
            got_v = {vv4, rdy4, busy4, oh4, bin4, ev4, er4};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL hold4 cyc=%0d got=%b exp=%b", i, got_v, exp_v);
            else n_pass++;
        end
        vr4 = 1'b1;
        #1;
        n_checks++;
        if (le4 !== eu) $display("FAIL lfsr_en4 got=%b exp=%b", le4, eu); else n_pass++;
        tick;
        vr4 = 1'b0;
        if (ee) begin
            n_checks++;
            if ({rdy4, busy4, vv4} !== 3'b100) $display("FAIL err_idle4 got=%b exp=100", {rdy4, busy4, vv4});
            else n_pass++;
        end else begin
            exp_v = {1'b0, 1'b0, 1'b1, eoh, 2'(eb), eev, ee};
            got_v = {vv4, rdy4, busy4, oh4, bin4, ev4, er4};
            n_checks++;
            if (got_v !== exp_v) $display("FAIL busy4 got=%b exp=%b", got_v, exp_v); else n_pass++;
            for (int i = 0; i < ddly; i++) tick;
            done4 = 1'b1;
            #1;
            n_checks++;
            if (rdy4 !== 1'b0) $display("FAIL done_cycle_ready4 got=%b exp=0", rdy4); else n_pass++;
            tick;
            done4 = 1'b0;
            n_checks++;
            if ({rdy4, busy4} !== 2'b10) $display("FAIL back_idle4 got=%b exp=10", {rdy4, busy4}); else n_pass++;
        end
        n_checks++;
        if (pulse4 - p0 !== int'(eu)) $display("FAIL pulses4 got=%0d exp=%0d", pulse4 - p0, eu);
        else n_pass++;
    endtask

    // Request on the 3-way instance with immediate ready and done.
    task automatic do_req3(input logic [2:0] v, input logic [2:0] l, input logic [1:0] r);
        int eb; bit ee, eev, eu;
        logic [2:0] eoh;
        logic [7:0] exp_v, got_v;
        int p0;
        model(3, {13'h0000, v}, {13'h0000, l}, int'(r), eb, ee, eev, eu);
        eoh = ee ? 3'b000 : 3'(1 << eb);
        vw3 = v; lk3 = l; lf3 = r; rv3 = 1'b1;
        p0 = pulse3;
        tick;
        rv3 = 1'b0; vw3 = 3'($urandom); lk3 = 3'($urandom);
        exp_v = {1'b1, eoh, 2'(eb), eev, ee};
        got_v = {vv3, oh3, bin3, ev3, er3};
        n_checks++;
        if (got_v !== exp_v) $display("FAIL offer3 v=%b l=%b r=%0d got=%b exp=%b", v, l, r, got_v, exp_v);
        else n_pass++;
        vr3 = 1'b1;
        tick;
        vr3 = 1'b0;
        if (!ee) begin
            done3 = 1'b1;
            tick;
            done3 = 1'b0;
        end
        n_checks++;
        if (rdy3 !== 1'b1 || pulse3 - p0 !== int'(eu))
            $display("FAIL end3 ready=%b pulses=%0d exp_ready=1 exp_pulses=%0d", rdy3, pulse3 - p0, eu);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        vr4 = 1'b1;
        #1;
        n_checks++;
        if ({rdy4, vv4, oh4, bin4, ev4, er4, le4, busy4} !== 12'b1_0_0000_00_0_0_0_0)
            $display("FAIL reset4 got=%b exp=100000000000", {rdy4, vv4, oh4, bin4, ev4, er4, le4, busy4});
        else n_pass++;
        vr4 = 1'b0;
        rst = 1'b0;
        tick;
        n_checks++;
        if ({rdy4, busy4, rdy3, busy3} !== 4'b1010)
            $display("FAIL after_reset got=%b exp=1010", {rdy4, busy4, rdy3, busy3});
        else n_pass++;
    endtask

    task automatic test_free_way;
        do_req4(4'b1011, 4'b0000, 2'd1, 0, 0);
        do_req4(4'b0110, 4'b0001, 2'd2, 1, 2);
    endtask

    task automatic test_lfsr_way;
        do_req4(4'b1111, 4'b0000, 2'd3, 0, 0);
        do_req4(4'b1111, 4'b0100, 2'd1, 0, 1);
    endtask

    task automatic test_wrap;
        do_req4(4'b1111, 4'b1001, 2'd3, 0, 0);
        do_req3(3'b111, 3'b000, 2'd3);
        do_req3(3'b111, 3'b001, 2'd3);
    endtask

    task automatic test_all_locked;
        do_req4(4'b0000, 4'b1111, 2'd2, 0, 0);
        do_req3(3'b101, 3'b111, 2'd1);
    endtask

    task automatic test_backpressure;
        do_req4(4'b1111, 4'b0010, 2'd1, 5, 10);
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cyc;
        do_req4(4'b1101, 4'b0000, 2'd0, 0, 0);
        do_req4(4'b1111, 4'b0000, 2'd2, 0, 0);
        do_req4(4'b1111, 4'b1111, 2'd2, 0, 0);
        n_checks++;
        if (cyc - c0 !== 8) $display("FAIL b2b_cycles got=%0d exp=8", cyc - c0); else n_pass++;
    endtask

    task automatic test_reset_mid;
        for (int ph = 0; ph < 2; ph++) begin
            vw4 = 4'hF; lk4 = 4'h0; lf4 = 2'd2; rv4 = 1'b1;
            tick;
            rv4 = 1'b0;
            if (ph == 1) begin
                vr4 = 1'b1;
                tick;
                vr4 = 1'b0;
            end
            n_checks++;
            if ({busy4, vv4} !== {1'b1, (ph == 0)}) $display("FAIL pre_reset ph=%0d got=%b", ph, {busy4, vv4});
            else n_pass++;
            rst = 1'b1;
            tick;
            rst = 1'b0;
            vr4 = 1'b1;
            #1;
            n_checks++;
            if ({rdy4, vv4, oh4, bin4, ev4, er4, le4, busy4} !== 12'b1_0_0000_00_0_0_0_0)
                $display("FAIL mid_reset ph=%0d got=%b exp=100000000000", ph,
                         {rdy4, vv4, oh4, bin4, ev4, er4, le4, busy4});
            else n_pass++;
            vr4 = 1'b0;
            do_req4(4'b0111, 4'b0000, 2'd0, 0, 1);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] l;
            l = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
            do_req4(4'($urandom), l, 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        for (int i = 0; i < 30; i++) begin
            do_req3(3'($urandom), 3'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_free_way();
        test_lfsr_way();
        test_wrap();
        test_all_locked();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
